// File: rtl/spike_threshold_adapt_if.sv
// Sample-stream and threshold bus between the adaptive threshold block
// and its neighbours: raw samples and gain come in, the threshold goes out.
interface spike_threshold_adapt_if;
  logic signed [15:0] data_in;
  logic               sample_en;
  logic        [4:0]  k_mult;
  logic signed [15:0] threshold;
  logic               thr_update;
  logic               thr_valid;

  modport master (
    output data_in, sample_en, k_mult,
    input  threshold, thr_update, thr_valid
  );

  modport slave (
    input  data_in, sample_en, k_mult,
    output threshold, thr_update, thr_valid
  );
endinterface

// File: rtl/spike_threshold_adapt.sv
// Adaptive spike threshold: windowed mean |x| -> sigma estimate -> gain,
// floor/clamp, then exponential smoothing into a negative threshold.
module spike_threshold_adapt #(
  parameter int                 LOG2_WIN    = 10,
  parameter int                 ALPHA_SHIFT = 3,
  parameter int                 MIN_MAG     = 64,
  parameter logic signed [15:0] INIT_THR    = -16'sd1000,
  parameter int                 SAT_LIMIT   = 30000
) (
  input logic                    clk,
  input logic                    rst,
  spike_threshold_adapt_if.slave bus
);
  localparam int ACC_W = 15 + LOG2_WIN;

  localparam logic signed [16:0] SAT_HI  = 17'(SAT_LIMIT);
  localparam logic signed [16:0] SAT_LO  = -SAT_HI;
  localparam logic        [21:0] MIN_W   = 22'(MIN_MAG);
  localparam logic        [21:0] MAX_W   = 22'd32767;

  typedef enum logic [1:0] {ACCUM, SCALE, UPDATE} state_t;

  state_t                    state_reg;
  logic [ACC_W-1:0]          acc_reg;
  logic [LOG2_WIN-1:0]       count_reg;
  logic [14:0]               mean_reg;
  logic [14:0]               target_reg;
  logic signed [15:0]        thr_reg;
  logic                      upd_reg;
  logic                      valid_reg;

  // Sample qualification and magnitude
  logic signed [16:0] x_ext;
  logic [15:0]        neg_x;
  logic [14:0]        mag;
  logic               artifact;
  logic               accept;
  logic [ACC_W-1:0]   sum_next;
  logic               window_done;
  logic [14:0]        mean_next;

  assign x_ext       = {bus.data_in[15], bus.data_in};
  assign artifact    = (x_ext <= SAT_LO) || (x_ext >= SAT_HI);
  assign accept      = bus.sample_en && !artifact;
  assign neg_x       = ~bus.data_in + 16'd1;
  // -32768 has no 15-bit magnitude, so it saturates
  assign mag         = (bus.data_in == 16'sh8000) ? 15'h7FFF
                     : (bus.data_in[15] ? neg_x[14:0] : bus.data_in[14:0]);
  assign sum_next    = acc_reg + ACC_W'(mag);
  assign window_done = accept && (count_reg == '1);
  assign mean_next   = 15'(sum_next >> LOG2_WIN);

  // Scaling path
  logic [16:0] sigma;
  logic [21:0] prod_full;
  logic [21:0] prod;
  logic [14:0] target_next;

  assign sigma     = {2'b00, mean_reg} + {4'b0000, mean_reg[14:2]};
  assign prod_full = 22'(sigma) * 22'(bus.k_mult);
  assign prod      = prod_full >> 2;

  always_comb begin
    target_next = prod[14:0];
    if (prod < MIN_W)
      target_next = MIN_W[14:0];
    else if (prod > MAX_W)
      target_next = MAX_W[14:0];
  end

  // Smoothing path, 17-bit signed so the difference cannot wrap
  logic signed [16:0] neg_target;
  logic signed [16:0] thr_ext;
  logic signed [16:0] diff;
  logic signed [16:0] step;
  logic signed [16:0] smoothed;
  logic signed [15:0] thr_next;

  assign neg_target = -$signed({2'b00, target_reg});
  assign thr_ext    = {thr_reg[15], thr_reg};
  assign diff       = neg_target - thr_ext;
  assign step       = diff >>> ALPHA_SHIFT;
  assign smoothed   = thr_ext + step;
  assign thr_next   = valid_reg ? smoothed[15:0] : neg_target[15:0];

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg  <= ACCUM;
      acc_reg    <= '0;
      count_reg  <= '0;
      mean_reg   <= '0;
      target_reg <= '0;
      thr_reg    <= INIT_THR;
      upd_reg    <= 1'b0;
      valid_reg  <= 1'b0;
    end else begin
      upd_reg <= 1'b0;

      // Accumulation runs regardless of compute state; a window of at least
      // four samples guarantees SCALE/UPDATE finish before the next close.
      if (accept) begin
        if (window_done) begin
          acc_reg   <= '0;
          count_reg <= '0;
          mean_reg  <= mean_next;
        end else begin
          acc_reg   <= sum_next;
          count_reg <= count_reg + 1'b1;
        end
      end

      case (state_reg)
        ACCUM: begin
          if (window_done)
            state_reg <= SCALE;
        end
        SCALE: begin
          target_reg <= target_next;
          state_reg  <= UPDATE;
        end
        UPDATE: begin
          thr_reg   <= thr_next;
          upd_reg   <= 1'b1;
          valid_reg <= 1'b1;
          state_reg <= ACCUM;
        end
        default: state_reg <= ACCUM;
      endcase
    end
  end

  assign bus.threshold  = thr_reg;
  assign bus.thr_update = upd_reg;
  assign bus.thr_valid  = valid_reg;
endmodule
